logip_cmd_decoder: RTL
======================

# logip_cmd_decoder

Consumes complete command frames from the UART receiver (`tuart_async_rx`: `data_o` / `rdy_o`) and turns them into core control actions.
- Holds the sampler configuration registers: divider, read/delay counts and flags.
- Pulses trigger-register writes, soft reset, arm and metadata requests.
- Answers the ID query itself by streaming a 4-byte ID to the UART transmitter.
- Sits between the RX stage and the trigger/sampler/TX blocks.

## Interface
Parameters:
- `DATA_BITS`, 8: UART word width. Only 8 is supported.
- `CMD_WIDTH_WORDS`, 5: words per frame. Only 5 is supported.
- `ID_WORD`, 32'h534C4131: ID response, sent least significant byte first ('1','A','L','S').

Ports (clock and reset first):
- `clk_i`, in, 1: clock.
- `rst_i`, in, 1: reset, synchronous, active-high.
- `cmd_i`, in, 40: frame from RX `data_o`. First received byte is in [39:32].
- `cmd_stb_i`, in, 1: frame valid for one cycle (RX `rdy_o`).
- `soft_rst_o`, out, 1: one-cycle pulse on opcode 0x00.
- `arm_o`, out, 1: one-cycle pulse on opcode 0x01.
- `meta_req_o`, out, 1: one-cycle pulse on opcode 0x04.
- `trg_we_o`, out, 1: one-cycle trigger-register write strobe.
- `trg_stage_o`, out, 2: trigger stage being written.
- `trg_sel_o`, out, 2: register selected within the stage. 0 = mask, 1 = value, 2 = config.
- `trg_data_o`, out, 32: trigger write data.
- `div_o`, out, 24: sample-clock divider.
- `read_cnt_o`, out, 16: read count.
- `delay_cnt_o`, out, 16: delay count.
- `flags_o`, out, 32: flags register.
- `tx_data_o`, out, 8: byte to the transmitter.
- `tx_stb_o`, out, 1: transmit request.
- `tx_busy_i`, in, 1: transmitter busy.
- `id_busy_o`, out, 1: ID response in progress.

## Operation
Frame fields:
- Opcode `op` = `cmd_i[39:32]`.
- Received argument bytes b1..b4 = `cmd_i[31:24]`, `[23:16]`, `[15:8]`, `[7:0]`.
- Argument `arg` = {b4,b3,b2,b1}, because the host sends least significant byte first.
- Short commands (op[7]=0) arrive padded to 5 bytes by the host driver. Their argument is ignored.

Decode is applied only in the cycle `cmd_stb_i`=1:
- 0x00: pulse `soft_rst_o`. Configuration registers are not cleared by this block.
- 0x01: pulse `arm_o`.
- 0x02: start the ID response if the ID FSM is IDLE, otherwise ignore.
- 0x04: pulse `meta_req_o`.
- 0x11 and 0x13 (XON/XOFF): no action.
- 0xC0–0xCF, with op[1:0] ≠ 3: pulse `trg_we_o`, `trg_stage_o`=op[3:2], `trg_sel_o`=op[1:0], `trg_data_o`=`arg`.
- 0xC3, 0xC7, 0xCB, 0xCF: no action.
- 0x80: `div_o` ← `arg[23:0]`.
- 0x81: `read_cnt_o` ← `arg[15:0]`, `delay_cnt_o` ← `arg[31:16]`.
- 0x82: `flags_o` ← `arg`.
- Any other opcode: silently dropped, no output changes.

ID FSM (states IDLE, SEND, WAIT; byte index `idx` 0..3):
- IDLE → SEND on an accepted 0x02, with `idx`=0.
- SEND: while `tx_busy_i`=0, drive `tx_stb_o`=1 for one cycle with `tx_data_o`=`ID_WORD[8*idx+7:8*idx]`, then go to WAIT.
- WAIT: hold exactly one cycle, so the transmitter can raise busy. Then go to SEND with `idx`+1, or to IDLE after `idx`=3.
- `id_busy_o`=1 in SEND and WAIT.
- Frames arriving during SEND/WAIT are still decoded (register writes, pulses). A repeated 0x02 is ignored.

Reset (`rst_i`=1 at a clock edge):
- All outputs go to 0, including `div_o`, the counts, `flags_o`, the pulses, `tx_stb_o` and `tx_data_o`.
- The FSM returns to IDLE, aborting an ID response mid-stream.
- `cmd_stb_i` is ignored in the reset cycle.

## Timing
- One register stage: `cmd_stb_i` at the edge of cycle N → pulses, trigger bus and register updates are valid in cycle N+1.
- Pulses last exactly one cycle. `trg_stage_o`, `trg_sel_o` and `trg_data_o` hold their last value after the strobe.
- ID: with `tx_busy_i` held low, the first `tx_stb_o` is in cycle N+1 and subsequent strobes come every 2 cycles (N+1, N+3, N+5, N+7). `id_busy_o` falls in N+9.
- When `tx_busy_i`=1 in SEND, the strobe is stalled with no upper bound. `tx_data_o` is stable while `tx_stb_o`=1.
- Back-to-back frames on consecutive cycles are each decoded. No frame is lost; there is no backpressure toward RX.

## Test plan
- After reset, all outputs read 0. Frame 40'h80_10_27_00_00 → `div_o`=24'h002710 in the next cycle, no pulses.
- Frame 40'h81_04_00_08_00 → `read_cnt_o`=16'h0004, `delay_cnt_o`=16'h0008.
- Frame 40'hC9_EF_BE_AD_DE → one `trg_we_o` pulse with `trg_stage_o`=2, `trg_sel_o`=1, `trg_data_o`=32'hDEADBEEF. Frame 40'hCB_… → no strobe.
- Frame 40'h02_00_00_00_00 with a TX model (busy for 10 cycles after each strobe) → bytes 0x31, 0x41, 0x4C, 0x53 in order, one strobe each, `id_busy_o` low afterwards. A second 0x02 sent mid-stream is ignored.
- 0x00 and 0x01 frames on consecutive cycles → `soft_rst_o` pulse, then `arm_o` pulse one cycle later. Frame 40'h55_… → no output change.
- Assert `rst_i` after the second ID byte → `tx_stb_o` stays 0 from then on, FSM IDLE, registers 0.

Source files
------------

// File: rtl/logip_cmd_decoder_if.sv
// logip_cmd_decoder_if
//   Command/response bundle between the UART RX stage, the command decoder
//   and the trigger / sampler / TX blocks.
//   cmd_i, cmd_stb_i        : complete frame from RX, valid for one cycle
//   soft_rst_o, arm_o,
//   meta_req_o              : one-cycle action pulses
//   trg_we_o, trg_stage_o,
//   trg_sel_o, trg_data_o   : trigger register write bus
//   div_o, read_cnt_o,
//   delay_cnt_o, flags_o    : sampler configuration registers
//   tx_data_o, tx_stb_o,
//   tx_busy_i               : byte stream to the UART transmitter
//   id_busy_o               : ID response in progress
//   modport slave  : the decoder
//   modport master : the surrounding RX/TX/core side
interface logip_cmd_decoder_if #(
   parameter int DATA_BITS       = 8,
   parameter int CMD_WIDTH_WORDS = 5
);
   logic [DATA_BITS*CMD_WIDTH_WORDS-1:0] cmd_i;
   logic                                 cmd_stb_i;
   logic                                 soft_rst_o;
   logic                                 arm_o;
   logic                                 meta_req_o;
   logic                                 trg_we_o;
   logic [1:0]                           trg_stage_o;
   logic [1:0]                           trg_sel_o;
   logic [31:0]                          trg_data_o;
   logic [23:0]                          div_o;
   logic [15:0]                          read_cnt_o;
   logic [15:0]                          delay_cnt_o;
   logic [31:0]                          flags_o;
   logic [DATA_BITS-1:0]                 tx_data_o;
   logic                                 tx_stb_o;
   logic                                 tx_busy_i;
   logic                                 id_busy_o;

   modport slave (
      input  cmd_i, cmd_stb_i, tx_busy_i,
      output soft_rst_o, arm_o, meta_req_o,
             trg_we_o, trg_stage_o, trg_sel_o, trg_data_o,
             div_o, read_cnt_o, delay_cnt_o, flags_o,
             tx_data_o, tx_stb_o, id_busy_o
   );

   modport master (
      output cmd_i, cmd_stb_i, tx_busy_i,
      input  soft_rst_o, arm_o, meta_req_o,
             trg_we_o, trg_stage_o, trg_sel_o, trg_data_o,
             div_o, read_cnt_o, delay_cnt_o, flags_o,
             tx_data_o, tx_stb_o, id_busy_o
   );
endinterface

// File: rtl/logip_cmd_decoder.sv
// logip_cmd_decoder
//   Decodes 5-byte command frames from the UART receiver into core actions:
//   configuration register writes, trigger register write strobes, action
//   pulses, and a self-contained 4-byte ID reply streamed to the transmitter.
//   Ports:
//     clk_i : clock
//     rst_i : synchronous active-high reset
//     bus   : logip_cmd_decoder_if.slave (frame in, control/config/TX out)
//   Frame decode has one register stage; the ID stream is driven directly
//   from the ID FSM state so the first strobe lands in the cycle after the
//   accepted frame.
module logip_cmd_decoder #(
   parameter int          DATA_BITS       = 8,
   parameter int          CMD_WIDTH_WORDS = 5,
   parameter logic [31:0] ID_WORD         = 32'h534C4131
) (
   input logic               clk_i,
   input logic               rst_i,
   logip_cmd_decoder_if.slave bus
);
   localparam int CMD_W = DATA_BITS * CMD_WIDTH_WORDS;

   typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, WAIT = 2'd2} id_state_e;

   typedef struct packed {
      logic [7:0]  op;
      logic [31:0] arg;
   } frame_t;

   logic [CMD_W-1:0] cmd;
   frame_t           fr;
   logic             is_trg;

   assign cmd = bus.cmd_i;
   // Host sends the argument least significant byte first.
   assign fr  = {cmd[39:32], cmd[7:0], cmd[15:8], cmd[23:16], cmd[31:24]};
   // 0xC0..0xCF address stage op[3:2]; select 3 does not exist.
   assign is_trg = (fr.op[7:4] == 4'hC) && (fr.op[1:0] != 2'd3);

   // ---------------------------------------------------------------
   // Registered decode: pulses, trigger bus, configuration registers
   // ---------------------------------------------------------------
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         bus.soft_rst_o  <= 1'b0;
         bus.arm_o       <= 1'b0;
         bus.meta_req_o  <= 1'b0;
         bus.trg_we_o    <= 1'b0;
         bus.trg_stage_o <= '0;
         bus.trg_sel_o   <= '0;
         bus.trg_data_o  <= '0;
         bus.div_o       <= '0;
         bus.read_cnt_o  <= '0;
         bus.delay_cnt_o <= '0;
         bus.flags_o     <= '0;
      end else begin
         bus.soft_rst_o <= 1'b0;
         bus.arm_o      <= 1'b0;
         bus.meta_req_o <= 1'b0;
         bus.trg_we_o   <= 1'b0;
         if (bus.cmd_stb_i) begin
            case (fr.op)
               8'h00: bus.soft_rst_o <= 1'b1;
               8'h01: bus.arm_o      <= 1'b1;
               8'h04: bus.meta_req_o <= 1'b1;
               8'h80: bus.div_o      <= fr.arg[23:0];
               8'h81: begin
                  bus.read_cnt_o  <= fr.arg[15:0];
                  bus.delay_cnt_o <= fr.arg[31:16];
               end
               8'h82: bus.flags_o    <= fr.arg;
               default: ;
            endcase
            // Stage/select/data are held after the strobe for the trigger block.
            if (is_trg) begin
               bus.trg_we_o    <= 1'b1;
               bus.trg_stage_o <= fr.op[3:2];
               bus.trg_sel_o   <= fr.op[1:0];
               bus.trg_data_o  <= fr.arg;
            end
         end
      end
   end

   // ---------------------------------------------------------------
   // ID reply FSM
   // ---------------------------------------------------------------
   id_state_e state, state_nxt;
   logic [1:0] idx, idx_nxt;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state <= IDLE;
         idx   <= '0;
      end else begin
         state <= state_nxt;
         idx   <= idx_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      idx_nxt       = idx;
      bus.tx_stb_o  = 1'b0;
      bus.tx_data_o = '0;
      bus.id_busy_o = 1'b0;
      case (state)
         IDLE: begin
            if (bus.cmd_stb_i && (fr.op == 8'h02)) begin
               state_nxt = SEND;
               idx_nxt   = '0;
            end
         end
         SEND: begin
            bus.id_busy_o = 1'b1;
            bus.tx_data_o = ID_WORD[{idx, 3'b000} +: DATA_BITS];
            // A strobe during the reset cycle would be a half-aborted byte.
            if (!bus.tx_busy_i) begin
               bus.tx_stb_o = !rst_i;
               state_nxt    = WAIT;
            end
         end
         WAIT: begin
            // One dead cycle lets the transmitter raise busy before the next byte.
            bus.id_busy_o = 1'b1;
            if (idx == 2'd3) begin
               state_nxt = IDLE;
               idx_nxt   = '0;
            end else begin
               state_nxt = SEND;
               idx_nxt   = idx + 2'd1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end
endmodule
